// File: rtl/ao_filter_bank.sv
// Multi-lane clocked AND-OR gate (w = c | (a & b)) with per-lane glitch filtering,
// rise/fall pulses and a saturating transition counter.
module ao_filter_bank #(
    parameter int WIDTH  = 4,
    parameter int STABLE = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             clr_count,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] pending,
    output logic [CNT_W-1:0] evt_count
);

    localparam int              LCW      = $clog2(STABLE + 1);
    localparam logic [LCW-1:0]  CNT_LAST = LCW'(STABLE - 1);
    localparam int              PW       = $clog2(WIDTH + 1);
    localparam int              SW       = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [CNT_W-1:0] EVT_MAX = '1;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_fire;
    wire  [WIDTH-1:0] w_lane_w;
    wire  [WIDTH-1:0] w_lane_rise;
    wire  [WIDTH-1:0] w_lane_fall;
    wire  [WIDTH-1:0] w_lane_pend;
    logic [CNT_W-1:0] r_evt;
    logic [PW-1:0]    w_pop;
    logic [SW-1:0]    w_sum;
    logic [CNT_W-1:0] w_evt_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else if (en) begin
            r_a <= a;
            r_b <= b;
            r_c <= c;
        end
    end

    assign w_raw = r_c | (r_a & r_b);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic [LCW-1:0] r_cnt;
            logic           r_w;
            logic           r_rise;
            logic           r_fall;
            logic           w_diff;

            // w is one bit, so "differs from w" already names the candidate value.
            assign w_diff     = w_raw[gi] ^ r_w;
            assign w_fire[gi] = en & w_diff & (r_cnt == CNT_LAST);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt  <= '0;
                    r_w    <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (en) begin
                        if (!w_diff) begin
                            r_cnt <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_cnt  <= '0;
                            r_w    <= w_raw[gi];
                            r_rise <= w_raw[gi];
                            r_fall <= ~w_raw[gi];
                        end else begin
                            r_cnt <= r_cnt + LCW'(1);
                        end
                    end
                end
            end

            assign w_lane_w[gi]    = r_w;
            assign w_lane_rise[gi] = r_rise;
            assign w_lane_fall[gi] = r_fall;
            assign w_lane_pend[gi] = (r_cnt != '0);
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + PW'(w_fire[i]);
        end
    end

    // Widened add so saturation is detected instead of wrapping.
    assign w_sum      = SW'(r_evt) + SW'(w_pop);
    assign w_evt_next = (w_sum > SW'(EVT_MAX)) ? EVT_MAX : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_evt <= '0;
        end else if (clr_count) begin
            r_evt <= '0;
        end else if (en) begin
            r_evt <= w_evt_next;
        end
    end

    assign w         = w_lane_w;
    assign rise      = w_lane_rise;
    assign fall      = w_lane_fall;
    assign pending   = w_lane_pend;
    assign evt_count = r_evt;

endmodule

// File: tb/tb_ao_filter_bank.sv
// Directed bench for ao_filter_bank: every edge is checked against a history-based
// reference model through a scoreboard queue, plus constant checks at key points.
module tb_ao_filter_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] a, b, c;
    logic       clr_count;
    logic [3:0] w, rise, fall, pending;
    logic [7:0] evt_count;

    int n_chk = 0;
    int n_err = 0;

    ao_filter_bank #(.WIDTH(4), .STABLE(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
        .clr_count(clr_count), .w(w), .rise(rise), .fall(fall),
        .pending(pending), .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ew;
        logic [3:0] erise;
        logic [3:0] efall;
        logic [3:0] epend;
        logic [7:0] eevt;
    } exp_t;

    exp_t sb_q[$];

    // Model: a lane flips when the last 3 enabled-edge raw samples all disagree with w.
    logic [3:0] m_a, m_b, m_c, m_w, m_rise, m_fall;
    logic [3:0] m_hist [0:2];
    int         m_evt;

    task automatic model_step();
        logic [3:0] raw;
        int s;
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_c = 0; m_w = 0; m_rise = 0; m_fall = 0; m_evt = 0;
            for (int j = 0; j < 3; j++) m_hist[j] = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (en) begin
                raw = m_c | (m_a & m_b);
                m_hist[2] = m_hist[1];
                m_hist[1] = m_hist[0];
                m_hist[0] = raw;
                for (int i = 0; i < 4; i++) begin
                    if (m_hist[0][i] != m_w[i] && m_hist[1][i] != m_w[i] && m_hist[2][i] != m_w[i]) begin
                        m_rise[i] = ~m_w[i];
                        m_fall[i] = m_w[i];
                        m_w[i]    = ~m_w[i];
                    end
                end
                m_a = a; m_b = b; m_c = c;
            end
            if (clr_count) m_evt = 0;
            else if (en) begin
                s = m_evt + $countones(m_rise | m_fall);
                m_evt = (s > 255) ? 255 : s;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.ew = m_w; e.erise = m_rise; e.efall = m_fall;
        e.epend = m_hist[0] ^ m_w;
        e.eevt = 8'(m_evt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_w", w, e.ew);
        chk("sb_rise", rise, e.erise);
        chk("sb_fall", fall, e.efall);
        chk("sb_pending", pending, e.epend);
        chk("sb_evt", evt_count, e.eevt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tt;
        logic       prev;
        int         pulses;
        logic [7:0] evt_before;
        logic [3:0] pend_exp;

        rst_n = 0; en = 1; a = 4'hF; b = 4'hF; c = 4'hF; clr_count = 0;
        tick(); tick();
        chk("rst_w", w, 0); chk("rst_rise", rise, 0); chk("rst_fall", fall, 0);
        chk("rst_evt", evt_count, 0); chk("rst_pending", pending, 0);

        // Test 1: latency of 3 edges after sampling
        rst_n = 1; a = 0; b = 0; c = 4'hF;
        tick(); tick(); tick();
        chk("t1_w_before", w, 0);
        tick();
        chk("t1_w", w, 4'hF); chk("t1_rise", rise, 4'hF); chk("t1_evt", evt_count, 4);
        tick();
        chk("t1_rise_clear", rise, 0);

        // Test 2: truth table on lane 0, other lanes held at 1
        tt = 8'hEA;
        prev = 1'b1;
        a = 0; b = 0; c = 4'hE;
        for (int i = 0; i < 8; i++) begin
            a[0] = i[2]; b[0] = i[1]; c[0] = i[0];
            pulses = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                pulses += int'(rise[0] | fall[0]);
            end
            chk("tt_w0", w[0], tt[i]);
            chk("tt_pulses", pulses, (tt[i] != prev) ? 1 : 0);
            prev = tt[i];
        end

        // Test 3: glitch rejection on lane 1
        a = 0; b = 0; c = 0;
        repeat (5) tick();
        evt_before = evt_count;
        c = 4'b0010;
        pend_exp = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) c = 0;
            tick();
            chk("g2_pend1", pending[1], pend_exp[k]);
            chk("g2_rise1", rise[1], 0);
            chk("g2_w1", w[1], 0);
        end
        chk("g2_evt", evt_count, evt_before);
        c = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) c = 0;
            tick();
        end
        chk("g3_rise1", rise[1], 1); chk("g3_w1", w[1], 1);
        repeat (5) tick();

        // Test 4: enable freeze on lane 2
        c = 4'b0100;
        tick(); tick(); tick();
        en = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("frz_w2", w[2], 0);
            chk("frz_pend2", pending[2], 1);
        end
        en = 1;
        tick();
        chk("frz_w2_resume", w[2], 1); chk("frz_rise2", rise[2], 1);

        // Test 5: saturating counter and clear priority
        c = 0;
        repeat (5) tick();
        for (int t = 0; t < 64; t++) begin
            c = (t % 2 == 0) ? 4'hF : 4'h0;
            repeat (4) tick();
        end
        chk("sat_evt", evt_count, 255); chk("sat_w", w, 0);
        c = 4'hF;
        repeat (4) tick();
        chk("sat_hold", evt_count, 255); chk("sat_w2", w, 4'hF);
        c = 0;
        repeat (3) tick();
        clr_count = 1;
        tick();
        chk("clr_fall", fall, 4'hF); chk("clr_evt", evt_count, 0);
        clr_count = 0;
        tick();
        chk("clr_evt_after", evt_count, 0);

        // Test 6: reset discards a partial count on lane 3
        c = 4'b1000;
        tick(); tick(); tick();
        chk("mid_pend3", pending[3], 1);
        rst_n = 0;
        tick();
        chk("mid_rst_w", w, 0); chk("mid_rst_pend", pending, 0);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_w3", w[3], (k == 3) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ao_filter_bank.md
Name: ao_filter_bank

Overview:
- Parametrised, clocked successor of the single-lane 3-input AND-OR gate w = c | (a & b).
- Evaluates the AND-OR function on WIDTH independent lanes and registers the inputs.
- Each lane output changes only after its raw result has differed from the current output for STABLE consecutive enabled cycles. This filters glitches such as the transient hazards seen on the ungated gate.
- Reports a one-cycle rise/fall pulse per lane and keeps a saturating count of all output transitions. Used as the deterministic, clocked replacement for the delay-only gate model.

Parameters:
- WIDTH, 4, number of independent AND-OR lanes (≥1).
- STABLE, 3, consecutive enabled cycles raw must disagree with w before w updates (≥1).
- CNT_W, 8, width of the transition event counter (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  global enable; 0 freezes all state.
- a  input  WIDTH  lane input a.
- b  input  WIDTH  lane input b.
- c  input  WIDTH  lane input c.
- clr_count  input  1  synchronous clear of evt_count.
- w  output  WIDTH  filtered AND-OR result, registered.
- rise  output  WIDTH  one-cycle pulse, lane w went 0→1 at this edge.
- fall  output  WIDTH  one-cycle pulse, lane w went 1→0 at this edge.
- pending  output  WIDTH  lane counter nonzero; a change is in progress. Combinational from registers.
- evt_count  output  CNT_W  saturating total of lane output transitions.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state regardless of en or clr_count:
  - a/b/c input regs=0, per-lane counters=0.
  - w=0, rise=0, fall=0, evt_count=0, so pending=0.
  - Reset mid-count discards the partial count.
- Input stage: with en=1, a/b/c are sampled into input regs every edge. raw[i] = c_r[i] | (a_r[i] & b_r[i]), combinational from the input regs.
- Per-lane counter cnt[i], width = clog2(STABLE+1). On each edge with en=1:
  - raw[i]==w[i] → cnt[i]<=0, no pulse.
  - raw[i]!=w[i] and cnt[i]<STABLE-1 → cnt[i]<=cnt[i]+1.
  - raw[i]!=w[i] and cnt[i]==STABLE-1 → w[i]<=raw[i], cnt[i]<=0, and rise[i] or fall[i]=1 for exactly this cycle.
- Any single-cycle return of raw to w resets that lane's count. Because w is 1 bit, no separate candidate register is needed.
- Latency: an input change set up before edge k appears on w (and pulses) at edge k+STABLE. STABLE=1 gives 1 edge after sampling, i.e. a registered gate plus input register.
- rise/fall default 0 each cycle; they are never both 1 on the same lane.
- en=0: input regs, cnt, w and evt_count hold; rise=fall=0. Counting resumes where it stopped when en returns to 1.
- evt_count (evaluated each edge, en=1):
  - Adds popcount(rise|fall) of that edge, saturating at 2^CNT_W-1 and never wrapping.
  - Lanes transitioning on the same edge all count.
  - clr_count=1 → evt_count<=0, taking priority over same-edge events, which are lost.
  - clr_count acts even when en=0.
- Lanes are fully independent. Simultaneous transitions on multiple lanes are legal and pulse together.

Test Plan (WIDTH=4, STABLE=3, CNT_W=8):
1. Reset: hold rst_n=0 for 2 edges with a=b=c=4'hF → w=0, rise=fall=0, evt_count=0, pending=0. Release, keep c=4'hF set before edge k → w=4'hF at edge k+3, rise=4'hF for one cycle, evt_count=4.
2. Truth table on lane 0: each (a,b,c) held 8 cycles → w[0] follows 000→0, 001→1, 010→0, 011→1, 100→0, 101→1, 110→1, 111→1, with one pulse per change at k+3 and none for unchanged transitions (e.g. 000→010).
3. Glitch rejection: from w[1]=0, set c[1]=1 for 2 cycles then 0 → w[1] stays 0, no rise, pending[1] high 2 cycles then low, evt_count unchanged. Repeat with a 3-cycle pulse → w[1] rises.
4. Enable freeze: raw[2] differs for 2 enabled cycles, en=0 for 5 cycles (w[2] holds, pending[2]=1), en=1 → w[2] toggles on the 1st enabled edge.
5. Counter: toggle all four lanes together 64 times → evt_count saturates at 255 and holds. Assert clr_count on an edge where fall=4'hF → evt_count=0.
6. Reset mid-operation: lane 3 at cnt=2, rst_n=0 one edge → w=0, pending=0. After release the lane needs a full 3 cycles again.
